sum_node_bf16: RTL
==================

# sum_node_bf16

Downstream consumer of the six-lane bf16 multiply chain. It collects the per-lane products as each lane's strobe fires, then reduces the enabled lanes into one bf16 result, one addition per cycle. The result is presented with a strobe/ack handshake to the next circuit layer. It is the sum-node stage of the probabilistic-circuit datapath.

## Interface
- `DW`, 16 — bf16 word width (matches `` `DW ``)
- `LANES`, 6 — number of product lanes
- `clk`  in  1  — rising-edge clock
- `rst`  in  1  — asynchronous, active-low reset
- `products`  in  LANES*DW  — lane i at bits [i*DW +: DW], driven by the multiply chain's outputs
- `prod_stbs`  in  LANES  — per-lane product valid, from the chain's final output strobes
- `lane_en`  in  LANES  — lanes included in the reduction; sampled when the first lane is captured
- `mode`  in  1  — 0 = sum, 1 = max (see Configuration)
- `in_ready`  out  1  — block accepts lane captures
- `sum`  out  DW  — bf16 result
- `sum_stb`  out  1  — result valid; held until acknowledged
- `sum_ack`  in  1  — downstream accepts the result

## Operation
- FSM states: IDLE, COLLECT, REDUCE, DONE.
- IDLE:
  - On the first cycle with any `prod_stbs[i] & lane_en[i]`, latch `lane_en` and `mode`.
  - Capture every such lane, set its captured flag, and go to COLLECT.
  - If `lane_en == 0`, stay in IDLE and ignore all strobes.
- COLLECT:
  - Capture lane i on `prod_stbs[i]` if it is enabled and not yet captured. The first capture wins; repeat strobes are ignored.
  - When every enabled lane is captured (including a capture in this same cycle), go to REDUCE with accumulator = +0.0 (0x0000) and index = 0.
  - If all enabled lanes are captured in the IDLE cycle itself, go directly to REDUCE.
- REDUCE:
  - Runs exactly LANES cycles, index 0..LANES-1.
  - Enabled lane: acc <= acc op lane[index]. Disabled lane: acc holds.
  - After index LANES-1, go to DONE.
- DONE:
  - `sum` = acc, `sum_stb` = 1.
  - On `sum_ack`, clear all flags and go to IDLE.
- Arithmetic (bf16: 1 sign, 8 exponent, 7 mantissa):
  - Align using guard, round and sticky bits; round to nearest even.
  - Subnormal inputs and results flush to signed zero.
  - x + (−x) = +0.0.
  - Exponent overflow gives ±inf (0x7F80/0xFF80).
  - Any NaN input, or inf + (−inf), gives canonical 0x7FC0; NaN is sticky through the rest of the reduction.
- Max op:
  - Uses IEEE ordering with −0 < +0.
  - NaN gives 0x7FC0.
  - Max mode starts the accumulator at 0xFF80 (−inf), not 0x0000.

## Timing
- Reset values: state IDLE, `in_ready` 1, `sum` 0x0000, `sum_stb` 0, all captured flags 0.
- `in_ready` = 1 in IDLE and COLLECT, 0 in REDUCE and DONE. Strobes arriving while `in_ready` = 0 are dropped.
- Latency: if the last enabled lane is captured at edge N, REDUCE occupies edges N+1..N+LANES and `sum_stb` rises after edge N+LANES+1. This is fixed regardless of how many lanes are enabled.
- `sum` is stable while `sum_stb` is high. `sum_ack` while `sum_stb` = 0 is ignored.
- Ack in DONE: `sum_stb` falls and `in_ready` rises at the next edge. Strobes in the ack cycle itself are not captured.
- Asserting `rst` in any state returns to reset values immediately and discards partial captures and the accumulator.

## Configuration
- `SUM_NODE_MAX_EN` defined: the `mode` port selects sum (0) or max (1), latched per operation.
- Undefined:
  - `mode` is ignored and the block always sums.
  - The max comparator is not synthesised.

## Structure
- Package `sum_node_pkg` holds:
  - the state enum;
  - bf16 field widths and exponent bias (127);
  - constants BF16_POS_ZERO 0x0000, BF16_NEG_INF 0xFF80, BF16_POS_INF 0x7F80, BF16_QNAN 0x7FC0.
- Sub-module `bf16_add`: a combinational single-cycle bf16 adder with the rounding, flush and special-value rules above. The FSM, capture registers, accumulator and max comparator stay in the top module.

## Test plan
- All six lanes 0x3F80 (1.0), `lane_en` 6'h3F, strobes together → `sum` = 0x40C0 (6.0), `sum_stb` exactly LANES+1 edges after capture.
- `lane_en` 6'b000011, lane0 = 0x3F80 and lane1 = 0x4000 strobed 3 cycles apart; other lanes strobed with garbage → 0x4040 (3.0).
- Lane0 = 0x7F80, lane1 = 0xFF80, other lanes 0x3F80, all enabled → 0x7FC0.
- Lane0 = 0x3F80, lane1 = 0x3380 (2⁻²⁴, far below 1.0's least-significant bit), only lanes 0–1 enabled → 0x3F80. Lane0 = 0x0001 (subnormal), only lane 0 enabled → 0x0000.
- `sum_ack` held low for 10 cycles in DONE while new strobes arrive → `sum` stable, strobes dropped. Ack → `in_ready` = 1 the next cycle.
- `rst` asserted mid-REDUCE → all reset values immediately; a fresh all-0x4000 operation then yields 0x4140 (12.0). With `SUM_NODE_MAX_EN` defined, `mode` = 1 and lanes {0x3F80, 0x4040, 0x4000, 0xBF80, 0x0000, 0x3F00} → 0x4040.

Source files
------------

// File: rtl/sum_node_pkg.sv
// Shared definitions for the bf16 sum node: FSM state encoding, bf16 field
// layout, special-value constants and small helpers for the max comparator.
package sum_node_pkg;

  localparam int BF16_W     = 16;
  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int BF16_BIAS  = 127;

  localparam logic [BF16_W-1:0] BF16_POS_ZERO = 16'h0000;
  localparam logic [BF16_W-1:0] BF16_NEG_INF  = 16'hFF80;
  localparam logic [BF16_W-1:0] BF16_POS_INF  = 16'h7F80;
  localparam logic [BF16_W-1:0] BF16_QNAN     = 16'h7FC0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REDUCE  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // All-ones exponent with a non-zero mantissa.
  function automatic logic bf16_is_nan(input logic [BF16_W-1:0] x);
    return (x[14:7] == 8'hFF) && (x[6:0] != 7'h00);
  endfunction

  // Maps a non-NaN bf16 to an unsigned key whose ordering matches IEEE
  // ordering, with -0 ranking just below +0.
  function automatic logic [BF16_W-1:0] bf16_order_key(input logic [BF16_W-1:0] x);
    return x[15] ? ~x : {1'b1, x[14:0]};
  endfunction

endpackage

// File: rtl/bf16_add.sv
// Single-cycle combinational bf16 adder. Operands are aligned with guard,
// round and sticky bits and rounded to nearest even. Subnormal inputs and
// results flush to signed zero, exact cancellation gives +0, overflow gives
// signed infinity, and any NaN or inf + (-inf) gives the canonical quiet NaN.
module bf16_add
  import sum_node_pkg::*;
(
  input  logic [BF16_W-1:0] i_a,
  input  logic [BF16_W-1:0] i_b,
  output logic [BF16_W-1:0] o_y
);

  logic        w_sa, w_sb;
  logic [7:0]  w_ea, w_eb;
  logic [6:0]  w_ma, w_mb;
  logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;

  logic        w_swap, w_sl;
  logic [7:0]  w_el, w_es, w_d;
  logic [6:0]  w_ml, w_ms;
  logic [10:0] w_lfull, w_sfull, w_shifted, w_sal, w_diff, w_norm;
  logic        w_lost;
  logic [11:0] w_s12;
  logic [3:0]  w_lz;
  logic        w_found;
  logic [9:0]  w_ex;
  logic        w_rup;
  logic [8:0]  w_m9;
  logic [6:0]  w_mant;
  logic        w_cancel, w_uflow;
  logic [15:0] w_core;

  assign w_sa = i_a[15];
  assign w_sb = i_b[15];
  assign w_ea = i_a[14:7];
  assign w_eb = i_b[14:7];
  assign w_ma = i_a[6:0];
  assign w_mb = i_b[6:0];

  // A zero exponent is treated as zero whatever the mantissa (subnormal flush).
  assign w_a_zero = (w_ea == 8'h00);
  assign w_b_zero = (w_eb == 8'h00);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_ma == 7'h00);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_mb == 7'h00);
  assign w_a_nan  = (w_ea == 8'hFF) && (w_ma != 7'h00);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_mb != 7'h00);

  // Finite, non-zero datapath: align the smaller operand, add or subtract,
  // renormalise and round to nearest even.
  always_comb begin
    w_swap    = ({w_eb, w_mb} > {w_ea, w_ma});
    w_sl      = w_swap ? w_sb : w_sa;
    w_el      = w_swap ? w_eb : w_ea;
    w_ml      = w_swap ? w_mb : w_ma;
    w_es      = w_swap ? w_ea : w_eb;
    w_ms      = w_swap ? w_ma : w_mb;
    w_d       = w_el - w_es;
    w_lfull   = {1'b1, w_ml, 3'b000};
    w_sfull   = {1'b1, w_ms, 3'b000};
    w_shifted = '0;
    w_lost    = 1'b0;
    w_s12     = '0;
    w_diff    = '0;
    w_lz      = '0;
    w_found   = 1'b0;
    w_norm    = '0;
    w_ex      = '0;
    w_cancel  = 1'b0;
    w_uflow   = 1'b0;
    w_rup     = 1'b0;
    w_m9      = '0;
    w_mant    = '0;
    w_core    = BF16_POS_ZERO;

    if (w_d > 8'd11) begin
      w_shifted = '0;
      w_lost    = 1'b1;
    end else begin
      w_shifted = w_sfull >> w_d;
      w_lost    = |(w_sfull & ((11'd1 << w_d) - 11'd1));
    end
    w_sal = {w_shifted[10:1], w_shifted[0] | w_lost};

    if (w_sa == w_sb) begin
      w_s12 = {1'b0, w_lfull} + {1'b0, w_sal};
      if (w_s12[11]) begin
        w_norm = {w_s12[11:2], w_s12[1] | w_s12[0]};
        w_ex   = {2'b00, w_el} + 10'd1;
      end else begin
        w_norm = w_s12[10:0];
        w_ex   = {2'b00, w_el};
      end
    end else begin
      w_diff = w_lfull - w_sal;
      for (int i = 10; i >= 0; i--) begin
        if (!w_found && w_diff[i]) begin
          w_lz    = 4'(10 - i);
          w_found = 1'b1;
        end
      end
      w_norm = w_diff << w_lz;
      w_ex   = {2'b00, w_el} - {6'd0, w_lz};
      if (w_diff == 11'd0) begin
        w_cancel = 1'b1;
      end else if ({2'b00, w_el} <= {6'd0, w_lz}) begin
        w_uflow = 1'b1;
      end
    end

    w_rup = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_m9  = {1'b0, w_norm[10:3]} + {8'd0, w_rup};
    if (w_m9[8]) begin
      w_mant = w_m9[7:1];
      w_ex   = w_ex + 10'd1;
    end else begin
      w_mant = w_m9[6:0];
    end

    if (w_cancel) begin
      w_core = BF16_POS_ZERO;
    end else if (w_uflow) begin
      w_core = {w_sl, 15'h0000};
    end else if (w_ex >= 10'd255) begin
      w_core = {w_sl, BF16_POS_INF[14:0]};
    end else begin
      w_core = {w_sl, w_ex[7:0], w_mant};
    end
  end

  // Special operands take priority over the finite datapath.
  always_comb begin
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
      o_y = BF16_QNAN;
    end else if (w_a_inf) begin
      o_y = {w_sa, BF16_POS_INF[14:0]};
    end else if (w_b_inf) begin
      o_y = {w_sb, BF16_POS_INF[14:0]};
    end else if (w_a_zero && w_b_zero) begin
      o_y = {w_sa & w_sb, 15'h0000};
    end else if (w_a_zero) begin
      o_y = i_b;
    end else if (w_b_zero) begin
      o_y = i_a;
    end else begin
      o_y = w_core;
    end
  end

endmodule

// File: rtl/sum_node_bf16.sv
// Sum node of the probabilistic-circuit datapath. Collects the per-lane bf16
// products from the multiply chain, then reduces the enabled lanes one per
// cycle over a fixed LANES-cycle window and offers the result on a
// strobe/ack handshake.
// Optional feature: define SUM_NODE_MAX_EN to let the mode input select a
// max reduction instead of a sum; otherwise mode is ignored and no max
// comparator is built.
module sum_node_bf16
  import sum_node_pkg::*;
#(
  parameter int DW    = 16,
  parameter int LANES = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES*DW-1:0] products,
  input  logic [LANES-1:0]    prod_stbs,
  input  logic [LANES-1:0]    lane_en,
  input  logic                mode,
  output logic                in_ready,
  output logic [DW-1:0]       sum,
  output logic                sum_stb,
  input  logic                sum_ack
);

  localparam int              IW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(LANES - 1);

  state_t           r_state;
  logic [LANES-1:0] r_en;
  logic [LANES-1:0] r_cap;
  logic [DW-1:0]    r_lane [LANES];
  logic [DW-1:0]    r_acc;
  logic [IW-1:0]    r_idx;
  logic [DW-1:0]    r_sum;
  logic             r_stb;

  logic [LANES-1:0] w_hit;
  logic [LANES-1:0] w_new;
  logic [LANES-1:0] w_take;
  logic [DW-1:0]    w_lane;
  logic [DW-1:0]    w_add_y;
  logic [DW-1:0]    w_step;
  logic [DW-1:0]    w_init_idle;
  logic [DW-1:0]    w_init_col;

  // IDLE considers only lanes enabled by the live lane_en; COLLECT uses the
  // latched enables and skips lanes that already hold a product.
  assign w_hit  = prod_stbs & lane_en;
  assign w_new  = prod_stbs & r_en & ~r_cap;
  assign w_take = (r_state == ST_IDLE)    ? w_hit :
                  (r_state == ST_COLLECT) ? w_new : '0;

  assign w_lane = r_lane[r_idx];

  bf16_add u_add (
    .i_a (r_acc),
    .i_b (w_lane),
    .o_y (w_add_y)
  );

`ifdef SUM_NODE_MAX_EN
  logic          r_mode;
  logic [DW-1:0] w_max_y;

  // Max of accumulator and current lane in IEEE order; NaN poisons the result.
  always_comb begin
    if (bf16_is_nan(r_acc) || bf16_is_nan(w_lane)) begin
      w_max_y = BF16_QNAN;
    end else if (bf16_order_key(w_lane) > bf16_order_key(r_acc)) begin
      w_max_y = w_lane;
    end else begin
      w_max_y = r_acc;
    end
  end

  assign w_step      = r_mode ? w_max_y : w_add_y;
  assign w_init_idle = mode   ? BF16_NEG_INF : BF16_POS_ZERO;
  assign w_init_col  = r_mode ? BF16_NEG_INF : BF16_POS_ZERO;

  // The operation's mode is frozen at the first capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode <= 1'b0;
    end else if ((r_state == ST_IDLE) && (|w_hit)) begin
      r_mode <= mode;
    end
  end
`else
  logic w_unused_mode;

  assign w_unused_mode = mode;
  assign w_step        = w_add_y;
  assign w_init_idle   = BF16_POS_ZERO;
  assign w_init_col    = BF16_POS_ZERO;
`endif

  // Lane product registers: load each lane on its accepted strobe only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) begin
        r_lane[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (w_take[i]) begin
          r_lane[i] <= products[i*DW +: DW];
        end
      end
    end
  end

  // Control FSM: capture, fixed-length reduction, then hold the result
  // until downstream acknowledges it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_en    <= '0;
      r_cap   <= '0;
      r_acc   <= BF16_POS_ZERO;
      r_idx   <= '0;
      r_sum   <= BF16_POS_ZERO;
      r_stb   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_hit) begin
            r_en  <= lane_en;
            r_cap <= w_hit;
            r_acc <= w_init_idle;
            r_idx <= '0;
            if (w_hit == lane_en) begin
              r_state <= ST_REDUCE;
            end else begin
              r_state <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          r_cap <= r_cap | w_new;
          if ((r_cap | w_new) == r_en) begin
            r_acc   <= w_init_col;
            r_idx   <= '0;
            r_state <= ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          if (r_en[r_idx]) begin
            r_acc <= w_step;
          end
          if (r_idx == LAST_IDX) begin
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        ST_DONE: begin
          if (!r_stb) begin
            r_sum <= r_acc;
            r_stb <= 1'b1;
          end else if (sum_ack) begin
            r_stb   <= 1'b0;
            r_cap   <= '0;
            r_en    <= '0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
  assign sum      = r_sum;
  assign sum_stb  = r_stb;

endmodule
